text_line_renderer: RTL and testbench

Parametrised renderer that draws one horizontal line of N_CHARS glyphs at a fixed screen position on the VGA pixel stream. It holds a writable character buffer and a synchronous font ROM. It emits a per-pixel text flag and a 3-bit RGB value, aligned by a fixed pipeline delay. It sits between the VGA sync generator (pixel_x/pixel_y/video_on) and the RGB output register, and replaces single-purpose fixed-string character blocks.

---
 rtl/text_pkg.sv | 19 +
 rtl/text_font_rom.sv | 30 +++
 rtl/text_line_renderer.sv | 147 ++++++++++++++
 tb/tb_text_line_renderer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants, width helper and character-buffer entry type for the
// text line renderer.
package text_pkg;
  localparam int GLYPH_W    = 8;
  localparam int MAX_CODE_W = 8;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << w) < value) w = w + 1;
    return w;
  endfunction

  typedef struct packed {
    logic                  blink;
    logic [MAX_CODE_W-1:0] code;
  } buf_entry_t;
endpackage

// File: rtl/text_font_rom.sv
// Synchronous font ROM, one 8-pixel glyph row per address {code,row}.
// Contents are a generated glyph pattern built at elaboration time.
module text_font_rom
  import text_pkg::*;
#(
  parameter int    CODE_W    = 6,
  parameter int    CHAR_H    = 16,
  parameter string FONT_FILE = ""
) (
  input  logic                            clk,
  input  logic [CODE_W+clog2(CHAR_H)-1:0] addr,
  output logic [GLYPH_W-1:0]              data
);
  localparam int ROW_W = clog2(CHAR_H);
  localparam int DEPTH = 1 << (CODE_W + ROW_W);

  logic [GLYPH_W-1:0] mem [DEPTH];

  // Code 0 is the blank glyph in every font.
  function automatic logic [GLYPH_W-1:0] fallback_glyph(input int code, input int row);
    if (code == 0) return '0;
    return GLYPH_W'((code * 37 + row * 11) ^ 'h5A);
  endfunction

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = fallback_glyph(a >> ROW_W, a % CHAR_H);
  end

  always_ff @(posedge clk) data <= mem[addr];
endmodule

// File: rtl/text_line_renderer.sv
// Draws one line of N_CHARS glyphs from a writable buffer, 3-clk pixel latency.
// Optional per-slot blinking is enabled by defining TEXT_BLINK_EN.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int         N_CHARS      = 8,
  parameter int         CODE_W       = 6,
  parameter int         CHAR_H       = 16,
  parameter int         GAP          = 4,
  parameter int         X0           = 303,
  parameter int         Y0           = 232,
  parameter logic [2:0] FG_RGB       = 3'b111,
  parameter logic [2:0] BG_RGB       = 3'b000,
  parameter int         BLINK_FRAMES = 30,
  parameter string      FONT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_en,
  input  logic [4:0]        wr_idx,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              wr_blink,
  output logic              text_on,
  output logic [2:0]        rgb
);
  localparam int ROW_W = clog2(CHAR_H);
  localparam int PITCH = GLYPH_W + GAP;

  buf_entry_t buffer [N_CHARS];
  logic       new_blink;
  logic       phase;

`ifdef TEXT_BLINK_EN
  localparam int CNT_W = clog2(BLINK_FRAMES + 1);
  logic [CNT_W-1:0] frame_cnt;

  assign new_blink = wr_blink;

  // Pixel (0,0) marks a new frame; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_wr_blink;
  assign unused_wr_blink = wr_blink;
  assign new_blink       = 1'b0;
  assign phase           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CHARS; k++) buffer[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N_CHARS; k++)
        if (wr_idx == 5'(k)) buffer[k] <= '{blink: new_blink, code: MAX_CODE_W'(wr_code)};
    end
  end

  logic [15:0]           x_ext, y_ext;
  logic                  row_in, sel_hit, sel_blink;
  logic [MAX_CODE_W-1:0] sel_code;
  logic [2:0]            sel_col;
  logic [ROW_W-1:0]      sel_row;

  assign x_ext   = {6'd0, pixel_x};
  assign y_ext   = {6'd0, pixel_y};
  assign row_in  = (y_ext >= 16'(Y0)) && (y_ext <= 16'(Y0 + CHAR_H - 1));
  assign sel_row = ROW_W'(y_ext - 16'(Y0));

  // One range comparator per slot; slot windows never overlap.
  always_comb begin
    sel_hit   = 1'b0;
    sel_code  = '0;
    sel_col   = '0;
    sel_blink = 1'b0;
    for (int k = 0; k < N_CHARS; k++) begin
      if (x_ext >= 16'(X0 + k * PITCH) && x_ext <= 16'(X0 + k * PITCH + GLYPH_W - 1)) begin
        sel_hit   = row_in;
        sel_code  = buffer[k].code;
        sel_blink = buffer[k].blink;
        sel_col   = 3'(x_ext - 16'(X0 + k * PITCH));
      end
    end
  end

  logic                  s0_hit, s0_vid, s1_hit, s1_vid;
  logic [MAX_CODE_W-1:0] s0_code;
  logic [ROW_W-1:0]      s0_row;
  logic [2:0]            s0_col, s1_col;
  logic [GLYPH_W-1:0]    rom_word;
  logic                  pix_on;
  logic                  unused_code;

  text_font_rom #(
    .CODE_W   (CODE_W),
    .CHAR_H   (CHAR_H),
    .FONT_FILE(FONT_FILE)
  ) u_rom (
    .clk (clk),
    .addr({s0_code[CODE_W-1:0], s0_row}),
    .data(rom_word)
  );

  assign unused_code = ^s0_code;
  assign pix_on      = s1_vid & s1_hit & rom_word[3'd7 - s1_col];

  // Bit 7 of the ROM word is the leftmost glyph column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_hit  <= 1'b0;
      s0_vid  <= 1'b0;
      s0_code <= '0;
      s0_row  <= '0;
      s0_col  <= '0;
      s1_hit  <= 1'b0;
      s1_vid  <= 1'b0;
      s1_col  <= '0;
      text_on <= 1'b0;
      rgb     <= 3'b000;
    end else begin
      s0_hit  <= sel_hit & ~(sel_blink & phase);
      s0_vid  <= video_on;
      s0_code <= sel_code;
      s0_row  <= sel_row;
      s0_col  <= sel_col;
      s1_hit  <= s0_hit;
      s1_vid  <= s0_vid;
      s1_col  <= s0_col;
      text_on <= pix_on;
      rgb     <= !s1_vid ? 3'b000 : (pix_on ? FG_RGB : BG_RGB);
    end
  end
endmodule

// File: tb/tb_text_line_renderer.sv
// Scoreboard bench for text_line_renderer (N_CHARS=3, distinct FG/BG colours).
// Blink checks are compiled in when TEXT_BLINK_EN is defined.
module tb_text_line_renderer;
  localparam int         N_CHARS      = 3;
  localparam int         CODE_W       = 6;
  localparam int         CHAR_H       = 16;
  localparam int         GAP          = 4;
  localparam int         X0           = 303;
  localparam int         Y0           = 232;
  localparam int         PITCH        = 8 + GAP;
  localparam logic [2:0] FG_RGB       = 3'b110;
  localparam logic [2:0] BG_RGB       = 3'b001;
  localparam int         BLINK_FRAMES = 2;
`ifdef TEXT_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic              clk      = 1'b0;
  logic              rst      = 1'b0;
  logic              video_on = 1'b0;
  logic [9:0]        pixel_x  = 10'd600;
  logic [9:0]        pixel_y  = 10'd400;
  logic              wr_en    = 1'b0;
  logic [4:0]        wr_idx   = 5'd0;
  logic [CODE_W-1:0] wr_code  = '0;
  logic              wr_blink = 1'b0;
  logic              text_on;
  logic [2:0]        rgb;

  always #5 clk = ~clk;

  text_line_renderer #(
    .N_CHARS(N_CHARS), .CODE_W(CODE_W), .CHAR_H(CHAR_H), .GAP(GAP),
    .X0(X0), .Y0(Y0), .FG_RGB(FG_RGB), .BG_RGB(BG_RGB),
    .BLINK_FRAMES(BLINK_FRAMES), .FONT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_code(wr_code), .wr_blink(wr_blink),
    .text_on(text_on), .rgb(rgb)
  );

  typedef struct {
    logic       txt;
    logic [2:0] col;
    int         x;
    int         y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic drv_valid = 1'b0;
  logic [2:0] vld;
  int   model_code[N_CHARS];
  bit   model_blink[N_CHARS];
  int   model_cnt;
  bit   model_phase;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Same generated font the ROM uses when no font file is given.
  function automatic logic [7:0] model_font(input int code, input int row);
    if (code == 0) return 8'h00;
    return 8'((code * 37 + row * 11) ^ 'h5A);
  endfunction

  function automatic exp_t model_pixel(input int x, input int y, input bit vid);
    exp_t e;
    logic [7:0] w;
    int start;
    e.x   = x;
    e.y   = y;
    e.txt = 1'b0;
    e.col = vid ? BG_RGB : 3'b000;
    if (vid && y >= Y0 && y < Y0 + CHAR_H) begin
      for (int k = 0; k < N_CHARS; k++) begin
        start = X0 + k * PITCH;
        if (x >= start && x < start + 8 && !(BLINK_BUILD && model_blink[k] && model_phase)) begin
          w = model_font(model_code[k], y - Y0);
          if (w[7 - (x - start)]) begin
            e.txt = 1'b1;
            e.col = FG_RGB;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input int x, input int y, input bit vid, input bit we = 1'b0,
                               input int idx = 0, input int code = 0, input bit blink = 1'b0);
    @(negedge clk);
    pixel_x   = 10'(x);
    pixel_y   = 10'(y);
    video_on  = vid;
    wr_en     = we;
    wr_idx    = 5'(idx);
    wr_code   = CODE_W'(code);
    wr_blink  = blink;
    drv_valid = 1'b1;
    sb.push_back(model_pixel(x, y, vid));
    if (we && idx < N_CHARS) begin
      model_code[idx]  = code;
      model_blink[idx] = blink;
    end
    if (x == 0 && y == 0) begin
      if (model_cnt == BLINK_FRAMES - 1) begin
        model_cnt   = 0;
        model_phase = !model_phase;
      end else begin
        model_cnt++;
      end
    end
  endtask

  task automatic scanRow(input int y, input int xa, input int xb, input bit vid);
    for (int x = xa; x <= xb; x++) applyStimulus(x, y, vid);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drv_valid = 1'b0;
      wr_en     = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) vld <= 3'b000;
    else      vld <= {vld[1:0], drv_valid};
  end

  always @(negedge clk) begin
    if (vld[2]) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput($sformatf("text_on(%0d,%0d)", mon_e.x, mon_e.y), 32'(text_on), 32'(mon_e.txt));
        checkOutput($sformatf("rgb(%0d,%0d)", mon_e.x, mon_e.y), 32'(rgb), 32'(mon_e.col));
      end
    end
  end

  initial begin
    exp_t pre;
    for (int k = 0; k < N_CHARS; k++) begin
      model_code[k]  = 0;
      model_blink[k] = 1'b0;
    end
    model_cnt   = 0;
    model_phase = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_text_on", 32'(text_on), 32'd0);
    checkOutput("reset_rgb", 32'(rgb), 32'd0);
    rst = 1'b1;

    scanRow(240, 300, 312, 1'b1);
    applyStimulus(600, 400, 1'b0, 1'b1, 0, 'h09, 1'b1);
    applyStimulus(600, 400, 1'b0, 1'b1, 1, 'h13, 1'b0);
    applyStimulus(600, 400, 1'b0, 1'b1, 2, 'h01, 1'b0);
    scanRow(240, 298, 340, 1'b1);
    scanRow(240, 303, 334, 1'b0);
    for (int y = Y0 - 1; y <= Y0 + CHAR_H; y++) scanRow(y, 302, 311, 1'b1);
    scanRow(236, 333, 340, 1'b1);
    applyStimulus(303, 232, 1'b1);

    applyStimulus(600, 400, 1'b0, 1'b1, N_CHARS, 'h11, 1'b0);
    applyStimulus(600, 400, 1'b0, 1'b1, 31, 'h11, 1'b0);
    scanRow(240, 298, 340, 1'b1);

    scanRow(240, 313, 314, 1'b1);
    applyStimulus(315, 240, 1'b1, 1'b1, 1, 'h10, 1'b0);
    scanRow(240, 316, 322, 1'b1);

`ifdef TEXT_BLINK_EN
    scanRow(240, 303, 322, 1'b1);
    for (int f = 1; f <= 4; f++) begin
      applyStimulus(0, 0, 1'b0);
      scanRow(240, 303, 322, 1'b1);
    end
`endif

    repeat (4) applyStimulus(329, 240, 1'b1);
    idle(4);
    pre = model_pixel(329, 240, 1'b1);
    checkOutput("pre_reset_text_on", 32'(text_on), 32'(pre.txt));
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_text_on", 32'(text_on), 32'd0);
    checkOutput("async_reset_rgb", 32'(rgb), 32'd0);
    for (int k = 0; k < N_CHARS; k++) begin
      model_code[k]  = 0;
      model_blink[k] = 1'b0;
    end
    model_cnt   = 0;
    model_phase = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("in_reset_text_on", 32'(text_on), 32'd0);
      checkOutput("in_reset_rgb", 32'(rgb), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_clk1_rgb", 32'(rgb), 32'd0);
    @(negedge clk);
    checkOutput("post_reset_clk2_rgb", 32'(rgb), 32'd0);
    @(negedge clk);
    checkOutput("post_reset_clk3_text_on", 32'(text_on), 32'd0);
    checkOutput("post_reset_clk3_rgb", 32'(rgb), 32'(BG_RGB));

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
